ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder.sv | 161 ++++++++++++++++
 tb/tb_ram_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Byte-addressed, big-endian RAM slave with a fixed LATENCY handshake (IDLE→WAIT→DONE). MOC holds until memEnable drops.
// Define RAM_ALIGN_CHECK_EN to reject misaligned word accesses. The byte-access select is byteSel because 'byte' is a reserved word.
module ram_responder #(
   parameter int DEPTH_BYTES = 512,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memEnable,
   input  logic        RW,
   input  logic        byteSel,
   input  logic        unSign,
   input  logic [31:0] address,
   input  logic [31:0] dataIn,
   output logic [31:0] dataOut,
   output logic        MOC,
   output logic        alignErr
);

   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            rw_q, rw_d;
   logic            byte_q, byte_d;
   logic            unsign_q, unsign_d;
   logic            moc_q, moc_d;
   logic            align_err_q, align_err_d;
   logic [31:0]     data_out_q, data_out_d;

   logic [7:0]      mem [DEPTH_BYTES];
   logic            mem_we;
   logic            misaligned;
   logic [AW-1:0]   word_base;
   logic [7:0]      rd_byte;
   logic [31:0]     rd_word;
   logic [31:0]     rd_data;
   logic            unused_addr_bits;

   assign unused_addr_bits = ^address[31:AW];

`ifdef RAM_ALIGN_CHECK_EN
   assign misaligned = ~byte_q & (addr_q[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   assign word_base = {addr_q[AW-1:2], 2'b00};
   assign rd_byte   = mem[addr_q];
   assign rd_word   = {mem[word_base], mem[{addr_q[AW-1:2], 2'b01}],
                       mem[{addr_q[AW-1:2], 2'b10}], mem[{addr_q[AW-1:2], 2'b11}]};

   always_comb begin
      rd_data = rd_word;
      if (byte_q) begin
         rd_data = {{24{~unsign_q & rd_byte[7]}}, rd_byte};
      end
      if (misaligned) begin
         rd_data = 32'd0;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rw_d        = rw_q;
      byte_d      = byte_q;
      unsign_d    = unsign_q;
      moc_d       = moc_q;
      align_err_d = align_err_q;
      data_out_d  = data_out_q;
      mem_we      = 1'b0;
      case (state_q)
         IDLE: begin
            if (memEnable) begin
               addr_d   = address[AW-1:0];
               wdata_d  = dataIn;
               rw_d     = RW;
               byte_d   = byteSel;
               unsign_d = unSign;
               cnt_d    = CW'(LATENCY - 1);
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               moc_d       = 1'b1;
               align_err_d = misaligned;
               mem_we      = rw_q & ~misaligned;
               if (!rw_q) begin
                  data_out_d = rd_data;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            // memEnable low here also covers a request dropped mid-WAIT: MOC lives one clock.
            if (!memEnable) begin
               moc_d       = 1'b0;
               align_err_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         moc_q       <= 1'b0;
         align_err_q <= 1'b0;
         data_out_q  <= 32'd0;
         addr_q      <= '0;
         wdata_q     <= 32'd0;
         rw_q        <= 1'b0;
         byte_q      <= 1'b0;
         unsign_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         moc_q       <= moc_d;
         align_err_q <= align_err_d;
         data_out_q  <= data_out_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rw_q        <= rw_d;
         byte_q      <= byte_d;
         unsign_q    <= unsign_d;
      end
   end

   // Array has no reset; reset on the performing edge suppresses the write.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         if (byte_q) begin
            mem[addr_q] <= wdata_q[7:0];
         end else begin
            mem[word_base]                  <= wdata_q[31:24];
            mem[{addr_q[AW-1:2], 2'b01}]    <= wdata_q[23:16];
            mem[{addr_q[AW-1:2], 2'b10}]    <= wdata_q[15:8];
            mem[{addr_q[AW-1:2], 2'b11}]    <= wdata_q[7:0];
         end
      end
   end

   assign dataOut  = data_out_q;
   assign MOC      = moc_q;
   assign alignErr = align_err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Randomized and directed bench for ram_responder against a byte-array reference model.
module tb_ram_responder;

   localparam int DEPTH = 512;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        reset, memEnable, RW, byteSel, unSign;
   logic [31:0] address, dataIn;
   logic [31:0] dataOut;
   logic        MOC, alignErr;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  ref_mem [DEPTH];
   logic [31:0] exp_last;

   ram_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .memEnable(memEnable), .RW(RW), .byteSel(byteSel),
      .unSign(unSign), .address(address), .dataIn(dataIn), .dataOut(dataOut),
      .MOC(MOC), .alignErr(alignErr)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic void model_access(input logic rw, input logic byt, input logic uns,
                                        input logic [31:0] addr, input logic [31:0] din,
                                        output logic [31:0] exp_dout, output logic exp_aerr);
      int unsigned a, base;
      logic        mis;
      logic [31:0] v;
      a    = addr % DEPTH;
      base = a - (a % 4);
      mis  = 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
      mis = !byt && (addr % 4 != 0);
`endif
      exp_aerr = mis;
      if (rw) begin
         if (!mis) begin
            if (byt) ref_mem[a] = din[7:0];
            else for (int k = 0; k < 4; k++) ref_mem[base + k] = din[31 - 8*k -: 8];
         end
         exp_dout = exp_last;
      end else begin
         if (mis) v = 32'd0;
         else if (byt) begin
            v = {24'd0, ref_mem[a]};
            if (!uns && ref_mem[a][7]) v = v | 32'hFFFF_FF00;
         end else begin
            v = 32'd0;
            for (int k = 0; k < 4; k++) v = (v << 8) | {24'd0, ref_mem[base + k]};
         end
         exp_last = v;
         exp_dout = v;
      end
   endfunction

   task automatic do_access(input logic rw, input logic byt, input logic uns,
                            input logic [31:0] addr, input logic [31:0] din,
                            output int lat, output logic [31:0] dout, output logic aerr,
                            output logic moc_hold, output logic [31:0] dout_hold,
                            output logic moc_after);
      int n;
      @(negedge clk);
      memEnable = 1'b1; RW = rw; byteSel = byt; unSign = uns; address = addr; dataIn = din;
      @(posedge clk); #1;
      RW = 1'($urandom); byteSel = 1'($urandom); unSign = 1'($urandom);
      address = $urandom; dataIn = $urandom;
      lat = -1; n = 0;
      while (lat < 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (MOC === 1'b1) lat = n;
      end
      dout = dataOut; aerr = alignErr;
      @(posedge clk); #1;
      moc_hold = MOC; dout_hold = dataOut;
      @(negedge clk);
      memEnable = 1'b0;
      @(posedge clk); #1;
      moc_after = MOC;
   endtask

   task automatic test_reset;
      reset = 1'b1; memEnable = 1'b0; RW = 1'b0; byteSel = 1'b0; unSign = 1'b0;
      address = 32'd0; dataIn = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (MOC !== 1'b0) begin n_bad++; $display("FAIL reset_moc: got %b want 0", MOC); end
      n_cmp++; if (dataOut !== 32'd0) begin n_bad++; $display("FAIL reset_dout: got %h want 0", dataOut); end
      n_cmp++; if (alignErr !== 1'b0) begin n_bad++; $display("FAIL reset_aerr: got %b want 0", alignErr); end
      @(negedge clk); reset = 1'b0;
      exp_last = 32'd0;
   endtask

   task automatic prefill;
      int lat; logic [31:0] d, dh, e; logic ae, ea, mh, ma;
      for (int i = 0; i < DEPTH / 4; i++) begin
         d = $urandom;
         model_access(1'b1, 1'b0, 1'b0, 32'(i * 4), d, e, ea);
         do_access(1'b1, 1'b0, 1'b0, 32'(i * 4), d, lat, d, ae, mh, dh, ma);
      end
   endtask

   task automatic test_word_rw;
      int lat; logic [31:0] d, dh, e; logic ae, ea, mh, ma;
      model_access(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, e, ea);
      do_access(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, lat, d, ae, mh, dh, ma);
      n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL word_wr_latency: got %0d want %0d", lat, LAT); end
      model_access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, e, ea);
      do_access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, lat, d, ae, mh, dh, ma);
      n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL word_rd_latency: got %0d want %0d", lat, LAT); end
      n_cmp++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_rd_data: got %h want deadbeef", d); end
      n_cmp++; if (mh !== 1'b1 || dh !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_rd_hold: got moc=%b d=%h want 1/deadbeef", mh, dh); end
      n_cmp++; if (ma !== 1'b0) begin n_bad++; $display("FAIL word_rd_clear: got moc=%b want 0", ma); end
   endtask

   task automatic test_endian;
      int lat; logic [31:0] d, dh, e; logic ae, ea, mh, ma;
      model_access(1'b1, 1'b0, 1'b0, 32'h20, 32'h11223344, e, ea);
      do_access(1'b1, 1'b0, 1'b0, 32'h20, 32'h11223344, lat, d, ae, mh, dh, ma);
      model_access(1'b0, 1'b1, 1'b1, 32'h20, 32'h0, e, ea);
      do_access(1'b0, 1'b1, 1'b1, 32'h20, 32'h0, lat, d, ae, mh, dh, ma);
      n_cmp++; if (d !== 32'h00000011) begin n_bad++; $display("FAIL endian_byte0: got %h want 00000011", d); end
      model_access(1'b0, 1'b1, 1'b1, 32'h23, 32'h0, e, ea);
      do_access(1'b0, 1'b1, 1'b1, 32'h23, 32'h0, lat, d, ae, mh, dh, ma);
      n_cmp++; if (d !== 32'h00000044) begin n_bad++; $display("FAIL endian_byte3: got %h want 00000044", d); end
   endtask

   task automatic test_byte_sign;
      int lat; logic [31:0] d, dh, e; logic ae, ea, mh, ma;
      logic [31:0] want [4];
      want[0] = 32'h000000A1; want[2] = 32'h000000C3; want[3] = 32'h000000D4;
      model_access(1'b1, 1'b0, 1'b0, 32'h30, 32'hA1B2C3D4, e, ea);
      do_access(1'b1, 1'b0, 1'b0, 32'h30, 32'hA1B2C3D4, lat, d, ae, mh, dh, ma);
      model_access(1'b1, 1'b1, 1'b0, 32'h31, 32'hFFFFFF80, e, ea);
      do_access(1'b1, 1'b1, 1'b0, 32'h31, 32'hFFFFFF80, lat, d, ae, mh, dh, ma);
      n_cmp++; if (d !== exp_last) begin n_bad++; $display("FAIL write_keeps_dout: got %h want %h", d, exp_last); end
      model_access(1'b0, 1'b1, 1'b0, 32'h31, 32'h0, e, ea);
      do_access(1'b0, 1'b1, 1'b0, 32'h31, 32'h0, lat, d, ae, mh, dh, ma);
      n_cmp++; if (d !== 32'hFFFFFF80) begin n_bad++; $display("FAIL byte_signext: got %h want ffffff80", d); end
      model_access(1'b0, 1'b1, 1'b1, 32'h31, 32'h0, e, ea);
      do_access(1'b0, 1'b1, 1'b1, 32'h31, 32'h0, lat, d, ae, mh, dh, ma);
      n_cmp++; if (d !== 32'h00000080) begin n_bad++; $display("FAIL byte_zeroext: got %h want 00000080", d); end
      for (int k = 0; k < 4; k++) begin
         if (k == 1) continue;
         model_access(1'b0, 1'b1, 1'b1, 32'(32'h30 + k), 32'h0, e, ea);
         do_access(1'b0, 1'b1, 1'b1, 32'(32'h30 + k), 32'h0, lat, d, ae, mh, dh, ma);
         n_cmp++; if (d !== want[k]) begin n_bad++; $display("FAIL byte_neighbour_%0d: got %h want %h", k, d, want[k]); end
      end
   endtask

   task automatic test_wrap;
      int lat; logic [31:0] d, dh, e; logic ae, ea, mh, ma;
      model_access(1'b1, 1'b0, 1'b0, 32'(DEPTH + 32'h40), 32'hCAFEF00D, e, ea);
      do_access(1'b1, 1'b0, 1'b0, 32'(DEPTH + 32'h40), 32'hCAFEF00D, lat, d, ae, mh, dh, ma);
      model_access(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, e, ea);
      do_access(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, lat, d, ae, mh, dh, ma);
      n_cmp++; if (d !== 32'hCAFEF00D) begin n_bad++; $display("FAIL wrap_read: got %h want cafef00d", d); end
   endtask

   task automatic test_align;
      int lat; logic [31:0] d, dh, e; logic ae, ea, mh, ma;
      logic [31:0] want_word;
      logic        want_ae;
`ifdef RAM_ALIGN_CHECK_EN
      want_word = 32'hCAFEF00D; want_ae = 1'b1;
`else
      want_word = 32'h5A5A1234; want_ae = 1'b0;
`endif
      model_access(1'b1, 1'b0, 1'b0, 32'h42, 32'h5A5A1234, e, ea);
      do_access(1'b1, 1'b0, 1'b0, 32'h42, 32'h5A5A1234, lat, d, ae, mh, dh, ma);
      n_cmp++; if (ae !== want_ae) begin n_bad++; $display("FAIL align_wr_flag: got %b want %b", ae, want_ae); end
      n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL align_wr_latency: got %0d want %0d", lat, LAT); end
      model_access(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, e, ea);
      do_access(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, lat, d, ae, mh, dh, ma);
      n_cmp++; if (d !== want_word) begin n_bad++; $display("FAIL align_landing: got %h want %h", d, want_word); end
      n_cmp++; if (ae !== 1'b0) begin n_bad++; $display("FAIL align_aligned_flag: got %b want 0", ae); end
      model_access(1'b0, 1'b0, 1'b0, 32'h41, 32'h0, e, ea);
      do_access(1'b0, 1'b0, 1'b0, 32'h41, 32'h0, lat, d, ae, mh, dh, ma);
      n_cmp++; if (d !== e || ae !== ea) begin n_bad++; $display("FAIL align_mis_read: got %h/%b want %h/%b", d, ae, e, ea); end
      n_cmp++; if (ma !== 1'b0) begin n_bad++; $display("FAIL align_flag_clear: got moc=%b want 0", ma); end
   endtask

   task automatic test_early_drop;
      logic [31:0] e, d; logic ea; int highs, first;
      model_access(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, e, ea);
      @(negedge clk);
      memEnable = 1'b1; RW = 1'b0; byteSel = 1'b0; unSign = 1'b0; address = 32'h20;
      @(posedge clk);
      @(negedge clk); memEnable = 1'b0;
      highs = 0; first = -1; d = 32'h0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (MOC === 1'b1) begin
            highs++;
            if (first < 0) begin first = i; d = dataOut; end
         end
      end
      n_cmp++; if (highs !== 1) begin n_bad++; $display("FAIL drop_pulse_width: got %0d want 1", highs); end
      n_cmp++; if (first !== LAT) begin n_bad++; $display("FAIL drop_latency: got %0d want %0d", first, LAT); end
      n_cmp++; if (d !== 32'h11223344) begin n_bad++; $display("FAIL drop_data: got %h want 11223344", d); end
   endtask

   task automatic test_reset_abort;
      int lat; logic [31:0] d, dh, e; logic ae, ea, mh, ma; int highs;
      model_access(1'b1, 1'b0, 1'b0, 32'h50, 32'h12345678, e, ea);
      do_access(1'b1, 1'b0, 1'b0, 32'h50, 32'h12345678, lat, d, ae, mh, dh, ma);
      @(negedge clk);
      memEnable = 1'b1; RW = 1'b1; byteSel = 1'b0; address = 32'h50; dataIn = 32'hAAAAAAAA;
      @(posedge clk);
      @(negedge clk); reset = 1'b1; memEnable = 1'b0;
      highs = 0;
      repeat (2) begin @(posedge clk); #1; if (MOC !== 1'b0) highs++; end
      n_cmp++; if (dataOut !== 32'd0) begin n_bad++; $display("FAIL abort_dout_reset: got %h want 0", dataOut); end
      @(negedge clk); reset = 1'b0;
      exp_last = 32'd0;
      repeat (4) begin @(posedge clk); #1; if (MOC !== 1'b0) highs++; end
      n_cmp++; if (highs !== 0) begin n_bad++; $display("FAIL abort_moc: got %0d high cycles want 0", highs); end
      model_access(1'b0, 1'b0, 1'b0, 32'h50, 32'h0, e, ea);
      do_access(1'b0, 1'b0, 1'b0, 32'h50, 32'h0, lat, d, ae, mh, dh, ma);
      n_cmp++; if (d !== 32'h12345678) begin n_bad++; $display("FAIL abort_no_write: got %h want 12345678", d); end
   endtask

   task automatic test_random;
      int lat; logic [31:0] d, dh, e, a, w; logic ae, ea, mh, ma, rw, byt, uns;
      for (int i = 0; i < 150; i++) begin
         rw = 1'($urandom); byt = 1'($urandom); uns = 1'($urandom);
         a = $urandom; w = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         model_access(rw, byt, uns, a, w, e, ea);
         do_access(rw, byt, uns, a, w, lat, d, ae, mh, dh, ma);
         n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, LAT); end
         n_cmp++; if (d !== e) begin n_bad++; $display("FAIL rand_dout[%0d] rw=%b b=%b u=%b a=%h: got %h want %h", i, rw, byt, uns, a, d, e); end
         n_cmp++; if (ae !== ea) begin n_bad++; $display("FAIL rand_aerr[%0d]: got %b want %b", i, ae, ea); end
         n_cmp++; if (mh !== 1'b1 || dh !== e) begin n_bad++; $display("FAIL rand_hold[%0d]: got %b/%h want 1/%h", i, mh, dh, e); end
         n_cmp++; if (ma !== 1'b0) begin n_bad++; $display("FAIL rand_clear[%0d]: got %b want 0", i, ma); end
      end
   endtask

   initial begin
      test_reset;
      prefill;
      test_word_rw;
      test_endian;
      test_byte_sign;
      test_wrap;
      test_align;
      test_early_drop;
      test_reset_abort;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
